// File: rtl/count_pkg.sv
// Shared definitions for the run-control counter sequencer: state encoding and default width.
package count_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage : count_pkg

// File: rtl/count_core.sv
// WIDTH-bit up-counter register with synchronous clear and increment enable.
module count_core #(
    parameter int WIDTH = count_pkg::DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign q = count_q;

endmodule : count_core

// File: rtl/count_sequencer.sv
// Start/pause/clear/terminal-count sequencer wrapped around a count_core up-counter.
module count_sequencer
    import count_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic             clear,
    input  logic             tick,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] q,
    output logic [1:0]       state,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             done_q, done_d;
    logic             core_clr;
    logic             core_en;
    logic [WIDTH-1:0] count;

    count_core #(.WIDTH(WIDTH)) u_core (
        .clk (clk),
        .rst (rst),
        .clr (core_clr),
        .en  (core_en),
        .q   (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            limit_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            limit_q <= limit_d;
            done_q  <= done_d;
        end
    end

    // Priority is clear > pause > start > tick; a lower-priority input is dropped when a higher one acts.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        limit_d  = limit_q;
        done_d   = 1'b0;
        core_clr = 1'b0;
        core_en  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                core_clr = 1'b1;
                if (!clear && start) begin
                    state_d = ST_RUN;
                    limit_d = limit;
                end
            end
            ST_RUN: begin
                if (clear) begin
                    state_d  = ST_IDLE;
                    core_clr = 1'b1;
                end else if (pause) begin
                    state_d = ST_PAUSE;
                end else if (start) begin
                    limit_d  = limit;
                    core_clr = 1'b1;
                end else if (tick) begin
                    if (count == limit_q) begin
                        done_d = 1'b1;
                        if (AUTO_RELOAD) core_clr = 1'b1;
                        else             state_d  = ST_DONE;
                    end else begin
                        core_en = 1'b1;
                    end
                end
            end
            ST_PAUSE: begin
                if (clear) begin
                    state_d  = ST_IDLE;
                    core_clr = 1'b1;
                end else if (!pause && start) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (clear) begin
                    state_d  = ST_IDLE;
                    core_clr = 1'b1;
                end else if (start) begin
                    state_d  = ST_RUN;
                    limit_d  = limit;
                    core_clr = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        state = state_q;
        busy  = (state_q == ST_RUN);
        done  = done_q;
        q     = count;
    end

endmodule : count_sequencer

// File: tb/tb_count_sequencer.sv
// Scoreboard bench: a behavioural model predicts each cycle's outputs, the queue is drained after the edge.
module tb_count_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, pause, clear, tick;
    logic [3:0] limit;
    logic [3:0] q0, q1;
    logic [1:0] st0, st1;
    logic       busy0, busy1, done0, done1;

    always #5 clk = ~clk;

    count_sequencer #(.WIDTH(4), .AUTO_RELOAD(1'b0)) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .clear(clear),
        .tick(tick), .limit(limit), .q(q0), .state(st0), .busy(busy0), .done(done0)
    );

    count_sequencer #(.WIDTH(4), .AUTO_RELOAD(1'b1)) dut_ar (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .clear(clear),
        .tick(tick), .limit(limit), .q(q1), .state(st1), .busy(busy1), .done(done1)
    );

    typedef struct {
        logic [3:0] q;
        logic [1:0] st;
        logic [3:0] lim;
        logic       done;
    } model_t;

    typedef struct {
        model_t m;
        bit     ar;
    } exp_t;

    model_t m0, m1;
    exp_t   sb[$];
    bit     sel_ar;
    int     n_checks = 0;
    int     n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural reference: one cycle of the sequencer as described in words.
    function automatic model_t model_next(model_t m, logic r, logic s, logic p, logic c,
                                          logic t, logic [3:0] l, bit ar);
        model_t n = m;
        n.done = 1'b0;
        if (r) begin
            n = '{q: 4'd0, st: 2'd0, lim: 4'd0, done: 1'b0};
            return n;
        end
        case (m.st)
            2'd0: if (!c && s) begin n.st = 2'd1; n.lim = l; n.q = 4'd0; end
            2'd1: begin
                if (c)      begin n.st = 2'd0; n.q = 4'd0; end
                else if (p) n.st = 2'd2;
                else if (s) begin n.lim = l; n.q = 4'd0; end
                else if (t) begin
                    if (m.q == m.lim) begin
                        n.done = 1'b1;
                        if (ar) n.q = 4'd0; else n.st = 2'd3;
                    end else begin
                        n.q = m.q + 4'd1;
                    end
                end
            end
            2'd2: begin
                if (c)            begin n.st = 2'd0; n.q = 4'd0; end
                else if (!p && s) n.st = 2'd1;
            end
            default: begin
                if (c)      begin n.st = 2'd0; n.q = 4'd0; end
                else if (s) begin n.st = 2'd1; n.lim = l; n.q = 4'd0; end
            end
        endcase
        return n;
    endfunction

    task automatic cyc(input logic r, input logic s, input logic p, input logic c,
                       input logic t, input logic [3:0] l);
        exp_t e;
        @(negedge clk);
        rst = r; start = s; pause = p; clear = c; tick = t; limit = l;
        m0 = model_next(m0, r, s, p, c, t, l, 1'b0);
        m1 = model_next(m1, r, s, p, c, t, l, 1'b1);
        sb.push_back('{m: (sel_ar ? m1 : m0), ar: sel_ar});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (e.ar) begin
            check("ar_q",     q1,    e.m.q);
            check("ar_state", st1,   e.m.st);
            check("ar_done",  done1, e.m.done);
            check("ar_busy",  busy1, e.m.st == 2'd1);
        end else begin
            check("q",     q0,    e.m.q);
            check("state", st0,   e.m.st);
            check("done",  done0, e.m.done);
            check("busy",  busy0, e.m.st == 2'd1);
        end
    endtask

    task automatic ticks(input int n, input logic [3:0] l);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 1, l);
    endtask

    initial begin
        rst = 1'b1; start = 0; pause = 0; clear = 0; tick = 0; limit = 0;
        m0 = '{q: 4'd0, st: 2'd0, lim: 4'd0, done: 1'b0};
        m1 = m0;
        sel_ar = 1'b0;

        // Reset and basic run to limit 5
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        check("reset_q", q0, 0);
        check("reset_state", st0, 0);
        cyc(0, 1, 0, 0, 0, 5);
        ticks(6, 5);
        check("basic_done", done0, 1);
        check("basic_state", st0, 3);
        check("basic_q", q0, 5);
        ticks(2, 5);
        check("basic_hold_q", q0, 5);
        check("basic_done_low", done0, 0);

        // Pause/resume without re-latching the limit
        cyc(0, 1, 0, 0, 0, 9);
        ticks(3, 9);
        check("pause_pre_q", q0, 3);
        cyc(0, 0, 1, 0, 0, 9);
        ticks(4, 9);
        check("paused_q", q0, 3);
        check("paused_state", st0, 2);
        cyc(0, 1, 0, 0, 0, 4);
        ticks(2, 4);
        check("resume_q", q0, 5);
        ticks(4, 4);
        check("resume_q9", q0, 9);
        check("resume_state", st0, 1);
        ticks(1, 4);
        check("resume_done", done0, 1);
        check("resume_state_done", st0, 3);

        // Priority
        cyc(0, 1, 0, 0, 0, 9);
        ticks(2, 9);
        cyc(0, 0, 1, 1, 1, 9);
        check("prio_clear_state", st0, 0);
        check("prio_clear_q", q0, 0);
        cyc(0, 1, 0, 0, 0, 9);
        ticks(2, 9);
        cyc(0, 0, 1, 0, 1, 9);
        check("prio_pause_q", q0, 2);
        check("prio_pause_state", st0, 2);

        // Boundaries: limit 0 and full-scale limit 15
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        ticks(1, 0);
        check("lim0_done", done0, 1);
        check("lim0_q", q0, 0);
        check("lim0_state", st0, 3);
        cyc(0, 1, 0, 0, 0, 15);
        ticks(15, 15);
        check("lim15_q", q0, 15);
        ticks(1, 15);
        check("lim15_done", done0, 1);
        check("lim15_nowrap", q0, 15);
        ticks(1, 15);
        check("lim15_hold", q0, 15);

        // Reset mid-run with coincident tick
        cyc(0, 1, 0, 0, 0, 9);
        ticks(7, 9);
        check("midrun_q7", q0, 7);
        cyc(1, 0, 0, 0, 1, 9);
        check("midrst_q", q0, 0);
        check("midrst_state", st0, 0);
        check("midrst_done", done0, 0);

        // Auto-reload instance, limit 3
        sel_ar = 1'b1;
        cyc(1, 0, 0, 0, 0, 3);
        cyc(0, 1, 0, 0, 0, 3);
        for (int i = 0; i < 10; i++) begin
            logic [3:0] exp_q;
            exp_q = 4'((i + 1) % 4);
            ticks(1, 3);
            check("ar_seq_q", q1, exp_q);
            check("ar_seq_done", done1, (i == 3 || i == 7));
            check("ar_seq_state", st1, 1);
        end

        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_count_sequencer

// File: doc/count_sequencer.md
# count_sequencer

Run-control sequencer for the lab counter datapath: a 2-bit FSM that starts, pauses, clears and terminates a WIDTH-bit up-counter against a programmable limit. It sits between the debounced push-button pulses and prescaler tick on one side and the 7-segment/LED display path on the other. It replaces the free-running counter wherever a counter needs start/stop/terminal-count behaviour.

## Interface
- WIDTH, 4, counter and limit width in bits
- AUTO_RELOAD, 0, 1 = wrap to 0 at limit and keep running; 0 = stop in DONE
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: begin, resume or restart counting
- pause  in  1  one-cycle pulse: freeze count while running
- clear  in  1  one-cycle pulse: abort and return to zero
- tick  in  1  count-enable strobe from prescaler, one cycle wide
- limit  in  WIDTH  terminal count, inclusive; latched on start
- q  out  WIDTH  current count, registered
- state  out  2  FSM state: IDLE=0, RUN=1, PAUSE=2, DONE=3
- busy  out  1  high while state==RUN (decode of state register)
- done  out  1  registered one-cycle pulse on terminal count

## Operation
- Reset (rst=1 at an edge): state=IDLE, q=0, done=0, latched limit=0; overrides every other input, including mid-run.
- Input priority per cycle: clear > pause > start > tick; at most one control action taken.
- IDLE: q=0. start → RUN, latch limit, q stays 0. pause and tick ignored.
- RUN: clear → IDLE, q=0. pause → PAUSE, q holds. start → restart: latch limit, q=0, stay RUN. tick with q<latched limit → q=q+1. tick with q==latched limit → done=1 for that one cycle; AUTO_RELOAD=0: → DONE, q holds limit; AUTO_RELOAD=1: q=0, stay RUN.
- PAUSE: start → RUN, q unchanged, limit not re-latched. clear → IDLE. tick ignored.
- DONE: start → RUN, re-latch limit, q=0. clear → IDLE, q=0. tick and pause ignored.
- limit=0: first tick in RUN raises done (stop, or stay at 0 when reloading).
- Changes to limit after start have no effect until the next latching start.
- Arithmetic: WIDTH-bit unsigned increment. Overflow is unreachable because the terminal compare fires first. Compare is equality against the latched limit.
- Control pulses are assumed one cycle wide. A held level acts as repeated pulses: held start in RUN restarts every cycle.

## Timing
- All outputs are registered or decoded from registered state; no combinational input-to-output path.
- tick sampled at edge n → new q visible after edge n (latency 1).
- Terminal tick at edge n → done=1 and state=DONE during cycle n+1; done=0 after edge n+1 unless a new terminal tick occurs.
- start/pause/clear at edge n → state/q updated after edge n.
- tick coincident with pause or clear is discarded. tick coincident with start in IDLE/DONE/RUN is discarded (q=0). tick coincident with start in PAUSE is discarded (resume only).

## Structure
- Shared package `count_pkg`: state encoding constants ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE (2-bit) and default WIDTH.
- One sub-module `count_core`: WIDTH-bit register with synchronous clr (to 0) and en (+1) inputs. The FSM drives clr/en and the terminal compare; the latched limit register lives in the FSM.

## Test plan
- Reset/basic: rst 2 cycles; limit=5, start, 6 ticks → q steps 0..5, done pulses once after the 6th tick, state=3, busy=0; further ticks leave q=5.
- Pause/resume: limit=9, start, 3 ticks (q=3), pause, 4 ticks → q stays 3, state=2; start, 2 ticks → q=5, limit not re-latched (change limit to 4 before resume; run continues to 9).
- Priority: in RUN at q=2, assert clear+pause+tick same cycle → state=0, q=0; assert pause+tick → q=2 held, state=2.
- Boundary: limit=0, start, 1 tick → done=1, q=0, state=3. limit=15 (WIDTH=4), 16 ticks → q reaches 15, done, no wrap to 0.
- AUTO_RELOAD=1, limit=3: 10 ticks → q sequence 1,2,3,0,1,2,3,0,1,2; done pulses after ticks 4 and 8; state stays 1.
- Reset mid-run: RUN at q=7, rst=1 together with tick → q=0, state=0, done=0 after the edge.
